// File: rtl/vec_elem_seq.sv
// vec_elem_seq: sequences one vector instruction element by element through an external PE.
// Each element is read, captured, then written back, taking three cycles with wr_ready high.
module vec_elem_seq #(
  parameter int VLEN = 128,
  parameter int AW   = 5 + $clog2(VLEN / 32),
  parameter int VLW  = $clog2(VLEN / 8) + 1
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           issue_valid,
  output logic           issue_ready,
  input  logic [4:0]     issue_vs1,
  input  logic [4:0]     issue_vs2,
  input  logic [4:0]     issue_vd,
  input  logic [VLW-1:0] issue_vl,
  input  logic [1:0]     issue_vsew,
  output logic [AW-1:0]  rd_addr_a,
  output logic [AW-1:0]  rd_addr_b,
  output logic [AW-1:0]  rd_addr_c,
  input  logic [31:0]    rd_data_a,
  input  logic [31:0]    rd_data_b,
  input  logic [31:0]    rd_data_c,
  output logic [31:0]    pe_a,
  output logic [31:0]    pe_b,
  output logic [31:0]    pe_c,
  input  logic [31:0]    pe_out,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [31:0]    wr_data,
  output logic [3:0]     wr_be,
  input  logic           wr_ready,
  output logic           done,
  output logic           err
);
  localparam int WW = AW - 5;
  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [4:0] vs1, vs2, vd;
  logic [VLW-1:0] vl, idx, max_vl, vl_c, wsh;
  logic [1:0] sew, lane;
  logic [31:0] op_a, op_b, op_c, emask;
  logic [4:0] off;
  logic [WW-1:0] word;
  assign max_vl = issue_vsew == 2'd0 ? VLW'(VLEN / 8) : issue_vsew == 2'd1 ? VLW'(VLEN / 16) : VLW'(VLEN / 32);
  assign vl_c = issue_vl > max_vl ? max_vl : issue_vl;
  assign wsh = sew == 2'd0 ? idx >> 2 : sew == 2'd1 ? idx >> 1 : idx;
  assign word = wsh[WW-1:0];
  // byte lane of the element inside its 32-bit word
  assign lane = sew == 2'd0 ? idx[1:0] : sew == 2'd1 ? {idx[0], 1'b0} : 2'd0;
  assign off = {lane, 3'b000};
  assign emask = sew == 2'd0 ? 32'h0000_00ff : sew == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff;
  assign rd_addr_a = {vs2, word};
  assign rd_addr_b = {vs1, word};
  assign rd_addr_c = {vd, word};
  assign wr_addr = {vd, word};
  assign pe_a = op_a;
  assign pe_b = op_b;
  assign pe_c = op_c;
  assign issue_ready = state == IDLE;
  assign wr_en = state == WRITE;
  assign wr_data = wr_en ? (pe_out & emask) << off : 32'd0;
  assign wr_be = !wr_en ? 4'd0 : (sew == 2'd0 ? 4'b0001 : sew == 2'd1 ? 4'b0011 : 4'b1111) << lane;
  assign done = state == DONE;
  assign err = done && sew == 2'd3;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = !issue_valid ? IDLE : (issue_vl == '0 || issue_vsew == 2'd3) ? DONE : READ;
      READ:  nxt = CAPT;
      CAPT:  nxt = WRITE;
      WRITE: nxt = !wr_ready ? WRITE : idx == vl - 1'b1 ? DONE : READ;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      {vs1, vs2, vd, sew} <= '0;
      vl <= '0;
      idx <= '0;
      {op_a, op_b, op_c} <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && issue_valid) begin
        {vs1, vs2, vd, sew} <= {issue_vs1, issue_vs2, issue_vd, issue_vsew};
        vl <= vl_c;
        idx <= '0;
      end
      if (state == CAPT) begin
        op_a <= (rd_data_a >> off) & emask;
        op_b <= (rd_data_b >> off) & emask;
        op_c <= (rd_data_c >> off) & emask;
      end
      if (state == WRITE && wr_ready) idx <= idx + 1'b1;
    end
  end
endmodule
